// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one
// instruction-memory request in flight, holds one returned word in a
// single-entry buffer and feeds the IF/ID register from that buffer.
module if_fetch #(
   parameter int                 XLEN     = 32,
   parameter logic [XLEN-1:0]    RESET_PC = '0,
   parameter logic [31:0]        NOP      = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,          // synchronous, active-low
   input  logic [5:0]       stall,        // {WB, MEM, EX, ID, IF, PC}
   input  logic             redirect,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             stallreq_if,
   output logic [XLEN-1:0]  if_pc,
   output logic [31:0]      if_instr,
   output logic             if_valid
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              buf_valid_q, buf_valid_d;
   logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
   logic [31:0]       buf_instr_q, buf_instr_d;
   logic              if_valid_q, if_valid_d;
   logic [XLEN-1:0]   if_pc_q, if_pc_d;
   logic [31:0]       if_instr_q, if_instr_d;
   logic              buf_fill;

   // stall[0] (PC) must not gate requests: the controller raises it in
   // response to stallreq_if, so honouring it here would deadlock.
   // The downstream bits are the concern of later stages.
   logic              unused_stall_bits;
   assign unused_stall_bits = ^{stall[5:3], stall[0]};

   // Memory-side outputs and the stall request. Nothing is requested while
   // the buffer is occupied or while a redirect is retargeting the PC.
   always_comb begin
      imem_req    = rst && (state_q == S_REQ) && !buf_valid_q && !redirect;
      imem_addr   = pc_q;
      stallreq_if = !buf_valid_q || !rst;
      if_pc       = if_pc_q;
      if_instr    = if_instr_q;
      if_valid    = if_valid_q;
   end

   // Fetch FSM: next PC, next state, and whether the returned word is kept.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      buf_fill = 1'b0;
      case (state_q)
         S_REQ: begin
            // A response arriving here is stale (e.g. after reset); ignore it.
            if (redirect) begin
               pc_d = redirect_pc;
            end else if (imem_req && imem_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               // If the word is already here it is simply dropped; otherwise
               // wait in DROP so the late response is not mistaken for new.
               state_d = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               buf_fill = 1'b1;
               pc_d     = pc_q + XLEN'(4);
               state_d  = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
            if (redirect) begin
               pc_d = redirect_pc;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // Buffer and IF/ID register update. A fill only happens while the
   // buffer is empty, so it never collides with a drain.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_instr_d  = if_instr_q;

      if (redirect) begin
         if_valid_d  = 1'b0;
         if_instr_d  = NOP;
         buf_valid_d = 1'b0;
      end else if (!stall[1]) begin
         if_valid_d  = buf_valid_q;
         if_pc_d     = buf_pc_q;
         if_instr_d  = buf_valid_q ? buf_instr_q : NOP;
         buf_valid_d = 1'b0;
      end else if (!stall[2]) begin
         if_valid_d  = 1'b0;
         if_instr_d  = NOP;
      end

      if (buf_fill) begin
         buf_valid_d = 1'b1;
         buf_pc_d    = pc_q;
         buf_instr_d = imem_rdata;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= NOP;
         if_valid_q  <= 1'b0;
         if_pc_q     <= '0;
         if_instr_q  <= NOP;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_instr_q  <= if_instr_d;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. Inputs are driven just after each rising
// edge; the IF/ID register is checked against a queue of expected
// {pc, instr} entries pushed whenever a response is returned un-flushed.
module tb_if_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stallreq_if;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   int   n_assert;
   int   n_fail;
   logic auto_stall;
   exp_t sb[$];

   if_fetch #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .NOP      (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stallreq_if (stallreq_if),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_valid    (if_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   // One clock: models the controller's registered stall vector and pops the
   // scoreboard whenever the edge was an IF/ID load that produced a real entry.
   task automatic tick();
      logic s;
      logic ld;
      exp_t e;
      s  = stallreq_if;
      ld = rst && !redirect && !stall[1];
      @(posedge clk);
      #1;
      if (auto_stall) stall = {4'b0000, s, s};
      if (ld && if_valid) begin
         if (sb.size() == 0) begin
            chk1("ifid_spurious", if_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            chk("ifid_pc", if_pc, e.pc);
            chk("ifid_instr", if_instr, e.instr);
            $display("IF/ID load pc=%h instr=%h", if_pc, if_instr);
         end
      end
   endtask

   // One full fetch with a single-cycle memory: wait for a request, check
   // its address, accept it, return the word the next cycle.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
      int   n;
      exp_t e;
      n = 0;
      imem_ready = 1'b1;
      #1;
      while (!imem_req && n < 50) begin
         tick();
         #1;
         n++;
      end
      chk1("fetch_req_seen", imem_req, 1'b1);
      chk("fetch_addr", imem_addr, exp_addr);
      $display("REQ addr=%h word=%h", imem_addr, word);
      tick();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      e.pc    = exp_addr;
      e.instr = word;
      sb.push_back(e);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
   endtask

   // Let the registered stall fall and the buffered word reach IF/ID.
   task automatic drain();
      tick();
      tick();
      chk1("drain_if_valid", if_valid, 1'b1);
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      auto_stall  = 1'b1;
      rst         = 1'b0;
      stall       = 6'b000011;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;

      // Reset state
      repeat (3) tick();
      #1;
      chk1("rst_imem_req", imem_req, 1'b0);
      chk1("rst_stallreq", stallreq_if, 1'b1);
      chk1("rst_if_valid", if_valid, 1'b0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, NOP);

      // First fetch from RESET_PC
      tick();
      rst = 1'b1;
      #1;
      chk1("t1_req", imem_req, 1'b1);
      chk("t1_addr", imem_addr, 32'h0);
      tick();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      sb.push_back('{pc: 32'h0, instr: 32'h0050_0093});
      #1;
      chk1("t1_wait_req", imem_req, 1'b0);
      tick();
      imem_rvalid = 1'b0;
      #1;
      chk1("t1_buf_stallreq", stallreq_if, 1'b0);
      chk1("t1_buf_req", imem_req, 1'b0);
      chk("t1_next_pc", imem_addr, 32'h4);
      drain();
      #1;
      chk1("t1_req2", imem_req, 1'b1);
      chk("t1_addr2", imem_addr, 32'h4);

      // Memory not ready for 5 cycles: request held steady
      for (int i = 0; i < 5; i++) begin
         chk1("t2_req", imem_req, 1'b1);
         chk("t2_addr", imem_addr, 32'h4);
         chk1("t2_stallreq", stallreq_if, 1'b1);
         tick();
         #1;
      end

      // Fetch into IF/ID, then hold IF/ID while the buffer refills
      fetch(32'h4, 32'h0010_0113);
      drain();
      auto_stall = 1'b0;
      stall      = 6'b000111;
      fetch(32'h8, 32'h0020_0193);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("t3_hold_valid", if_valid, 1'b1);
         chk("t3_hold_pc", if_pc, 32'h4);
         chk("t3_hold_instr", if_instr, 32'h0010_0113);
         chk1("t3_no_req", imem_req, 1'b0);
         tick();
      end
      stall = 6'b000011;
      tick();
      #1;
      chk1("t3_bubble_valid", if_valid, 1'b0);
      chk("t3_bubble_instr", if_instr, NOP);
      chk1("t3_buf_kept", stallreq_if, 1'b0);
      stall      = 6'b000000;
      auto_stall = 1'b1;
      tick();
      chk1("t3_release_valid", if_valid, 1'b1);

      // Redirect while waiting; response arrives two cycles later
      imem_ready = 1'b1;
      #1;
      chk1("t4_req", imem_req, 1'b1);
      chk("t4_addr", imem_addr, 32'hC);
      tick();
      imem_ready  = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chk1("t4_wait_req", imem_req, 1'b0);
      tick();
      redirect = 1'b0;
      #1;
      chk1("t4_flush_valid", if_valid, 1'b0);
      chk1("t4_drop_req", imem_req, 1'b0);
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk1("t4_drop_req2", imem_req, 1'b0);
      tick();
      imem_rvalid = 1'b0;
      #1;
      chk1("t4_restart_req", imem_req, 1'b1);
      chk("t4_restart_addr", imem_addr, 32'h100);
      chk1("t4_stallreq", stallreq_if, 1'b1);
      fetch(32'h100, 32'h0030_0213);
      drain();

      // Redirect coincident with the response
      imem_ready = 1'b1;
      #1;
      chk("t5_addr", imem_addr, 32'h104);
      tick();
      imem_ready  = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAAD_F00D;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      #1;
      chk1("t5_req", imem_req, 1'b1);
      chk("t5_addr2", imem_addr, 32'h200);
      chk1("t5_if_valid", if_valid, 1'b0);
      fetch(32'h200, 32'h0040_0293);
      drain();

      // PC wrap from the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      chk1("t6_redirect_req", imem_req, 1'b0);
      tick();
      redirect = 1'b0;
      #1;
      chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h0050_0313);
      #1;
      chk("t6_wrapped_pc", imem_addr, 32'h0);
      drain();
      #1;
      chk1("t6_req", imem_req, 1'b1);
      chk("t6_addr2", imem_addr, 32'h0);

      // Reset while waiting; a stale response afterwards is ignored
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      rst        = 1'b0;
      tick();
      #1;
      chk1("t7_rst_req", imem_req, 1'b0);
      chk1("t7_rst_stallreq", stallreq_if, 1'b1);
      chk1("t7_rst_valid", if_valid, 1'b0);
      rst         = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1234_5678;
      #1;
      chk1("t7_req", imem_req, 1'b1);
      chk("t7_addr", imem_addr, 32'h0);
      tick();
      imem_rvalid = 1'b0;
      #1;
      chk1("t7_stale_ignored", stallreq_if, 1'b1);
      chk1("t7_req2", imem_req, 1'b1);
      chk("t7_addr2", imem_addr, 32'h0);
      repeat (4) tick();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
